// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the counter width helper.
package multiplicador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned N_DEFAULT = 4;

  // Counter must reach N, so it needs $clog2(N+1) bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multiplicador_seq_n_dp.sv
// Shift-add datapath: operand capture with sign/magnitude conversion,
// accumulator, (N+1)-bit adder, shifter and final sign correction.
module mult_shift_add_dp
  import multiplicador_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           last,
  input  logic           sgn,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product
);

  // -2^(N-1) maps to 2^(N-1), which still fits in N unsigned bits.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
    return v[N-1] ? (~v + 1'b1) : v;
  endfunction

  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic           sign_flag;
  logic           sgn_r;

  logic [N:0]     addend;
  logic [N:0]     sum;
  logic [2*N-1:0] acc_next;
  logic [2*N-1:0] result;

  assign addend   = mplier[0] ? {1'b0, mcand} : '0;
  assign sum      = {1'b0, acc[2*N-1:N]} + addend;
  assign acc_next = {sum, acc[N-1:1]};
  assign result   = (sign_flag && sgn_r) ? (~acc_next + 1'b1) : acc_next;

  // NOTE: every state register, product included, is cleared by the async
  // reset so an aborted operation leaves nothing stale behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      sign_flag <= 1'b0;
      sgn_r     <= 1'b0;
      product   <= '0;
    end else if (load) begin
      mcand     <= sgn ? magnitude(multiplicand) : multiplicand;
      mplier    <= sgn ? magnitude(multiplier) : multiplier;
      acc       <= '0;
      sign_flag <= multiplicand[N-1] ^ multiplier[N-1];
      sgn_r     <= sgn;
    end else if (step) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      acc    <= acc_next;
      mplier <= mplier >> 1;
      if (last) begin
        product <= result;
      end
    end
  end

endmodule

// File: rtl/multiplicador_seq_n.sv
// Sequential N-bit signed/unsigned multiplier: IDLE/BUSY/DONE control and
// step counter around the shift-add datapath.
module multiplicador_seq_n
  import multiplicador_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           St,
  input  logic           Sgn,
  input  logic [N-1:0]   Multiplicando,
  input  logic [N-1:0]   Multiplicador,
  output logic           Idle,
  output logic           Done,
  output logic [2*N-1:0] Produto
);

  localparam int unsigned CW = cnt_width(N);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          load;
  logic          step;
  logic          last;

  assign load = (state == IDLE) && St;
  assign step = (state == BUSY);
  assign last = step && (cnt == CW'(N - 1));
  assign Idle = (state == IDLE);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (St) begin
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt + CW'(1);
          // Final step: the datapath loads Produto on this same edge.
          if (cnt == CW'(N - 1)) begin
            state <= DONE;
            Done  <= 1'b1;
          end
        end
        DONE: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  mult_shift_add_dp #(.N(N)) u_dp (
    .clk          (Clk),
    .rst          (Rst),
    .load         (load),
    .step         (step),
    .last         (last),
    .sgn          (Sgn),
    .multiplicand (Multiplicando),
    .multiplier   (Multiplicador),
    .product      (Produto)
  );

endmodule
